seg_scan_ctrl: RTL

Time-multiplexing scan controller for the board's 8-digit common-anode 7-segment display. It takes the parallel segment-pattern frame produced by the receive/display-flow path and drives one digit at a time. Each digit is preceded by a blanking gap to suppress ghosting. The frame is double-buffered so a shift mid-scan never tears. It sits between the UART display-flow shifter and the top-level `led_en`/`led_seg` pins.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_phase_timer.sv | 42 ++++
 rtl/seg_scan_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display path
// (display-flow shifter, ASCII decoder, scan controller).
package seg_pkg;

  localparam logic [7:0] SEG_BLANK       = 8'hFF;
  localparam int         DIGITS_ON_BOARD = 8;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg_phase_timer.sv
// Phase counter for the digit scan: counts cycles spent in the current
// BLANK/DRIVE phase and flags the last one; reloads to zero on load or done.
module seg_phase_timer
  import seg_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  scan_state_e phase_i,
  output logic        phase_done_o
);

  localparam int CNT_W = $clog2(max_int(DIGIT_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST =
    CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    phase_done_o = 1'b0;
    if (phase_i == DRIVE) begin
      phase_done_o = (cnt_q == DRIVE_LAST);
    end else begin
      // A zero-length blank phase is finished as soon as it is entered.
      phase_done_o = (BLANK_CYCLES == 0) || (cnt_q == BLANK_LAST);
    end
    cnt_d = (load_i || phase_done_o) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of a common-anode 7-segment display with a blanking
// gap before each digit and a frame shadow that only updates at frame wrap.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = DIGITS_ON_BOARD,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [8*NUM_DIGITS-1:0] frame_in,
  output logic [NUM_DIGITS-1:0]   led_en,
  output logic [7:0]              led_seg,
  output logic                    frame_tick
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [8*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    en_q;
  logic [NUM_DIGITS-1:0]   led_en_q, led_en_d;
  logic [7:0]              led_seg_q, led_seg_d;
  logic                    tick_q, tick_d;
  logic                    timer_ld;
  logic                    phase_done;

  // Any enable-low cycle and the first cycle back restart the phase count.
  assign timer_ld = !en || !en_q;

  seg_phase_timer #(
    .DIGIT_CYCLES (DIGIT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (timer_ld),
    .phase_i      (state_q),
    .phase_done_o (phase_done)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    tick_d   = 1'b0;

    if (!en) begin
      state_d  = BLANK;
      idx_d    = '0;
      shadow_d = frame_in;
    end else if (!en_q) begin
      state_d = BLANK;
      idx_d   = '0;
      tick_d  = 1'b1;
    end else if (phase_done) begin
      if (state_q == BLANK) begin
        state_d = DRIVE;
      end else begin
        state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        if (idx_q == IDX_LAST) begin
          idx_d    = '0;
          shadow_d = frame_in;
          tick_d   = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end

    // Outputs are decoded from next state so pins and state move together.
    led_en_d  = '1;
    led_seg_d = SEG_BLANK;
    if (state_d == DRIVE) begin
      led_en_d[idx_d] = 1'b0;
      led_seg_d       = shadow_d[8*idx_d +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BLANK;
      idx_q     <= '0;
      shadow_q  <= '1;
      // Reset as "was enabled" so leaving reset does not emit a frame tick.
      en_q      <= 1'b1;
      led_en_q  <= '1;
      led_seg_q <= SEG_BLANK;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      en_q      <= en;
      led_en_q  <= led_en_d;
      led_seg_q <= led_seg_d;
      tick_q    <= tick_d;
    end
  end

  assign led_en     = led_en_q;
  assign led_seg    = led_seg_q;
  assign frame_tick = tick_q;

endmodule
